// File: rtl/modular_remainder_unit_if.sv
// Handshake bundle between a product source and the modular remainder unit.
// The slave modport is the reducer; the master modport is its upstream/downstream partner.
interface modular_remainder_unit_if #(
   parameter int PROD_WIDTH = 96,
   parameter int MOD_WIDTH  = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic [PROD_WIDTH-1:0] product;
   logic [MOD_WIDTH-1:0]  modulus;
   logic                  out_valid;
   logic                  out_ready;
   logic [MOD_WIDTH-1:0]  remainder;
   logic                  err_mod0;

   modport master (
      output in_valid, product, modulus, out_ready,
      input  in_ready, out_valid, remainder, err_mod0
   );

   modport slave (
      input  in_valid, product, modulus, out_ready,
      output in_ready, out_valid, remainder, err_mod0
   );
endinterface

// File: rtl/modular_remainder_unit.sv
// Restoring shift-subtract reduction of a product modulo a modulus, one product bit per cycle.
//
//   state | meaning
//   IDLE  | ready for an operation; accept latches product and modulus
//   RUN   | one dividend bit shifted into the partial remainder per cycle
//   DONE  | result held on remainder/err_mod0 until out_ready
module modular_remainder_unit #(
   parameter int PROD_WIDTH = 96,
   parameter int MOD_WIDTH  = 64
) (
   input logic                    clk,
   input logic                    rst_n,
   modular_remainder_unit_if.slave bus
);
   localparam int CW = $clog2(PROD_WIDTH);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [PROD_WIDTH-1:0] shift_q;
   logic [MOD_WIDTH-1:0]  mod_q;
   logic [MOD_WIDTH-1:0]  r_q;
   logic [CW-1:0]         cnt_q;
   logic [MOD_WIDTH-1:0]  rem_q;
   logic                  err_q;

   logic                  accept;
   logic [MOD_WIDTH:0]    t;
   logic [MOD_WIDTH:0]    m_ext;
   logic [MOD_WIDTH-1:0]  r_nxt;

   assign accept = (state_q == IDLE) && bus.in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.in_valid) state_d = (bus.modulus == '0) ? DONE : RUN;
         RUN:  if (cnt_q == '0)  state_d = DONE;
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
   end

   // The partial remainder stays below the modulus, so it fits MOD_WIDTH bits;
   // only the shifted trial value needs the extra bit for the compare.
   always_comb begin
      t     = {r_q, shift_q[PROD_WIDTH-1]};
      m_ext = {1'b0, mod_q};
      r_nxt = (t >= m_ext) ? MOD_WIDTH'(t - m_ext) : t[MOD_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         mod_q   <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else if (accept) begin
         shift_q <= bus.product;
         mod_q   <= bus.modulus;
         r_q     <= '0;
         cnt_q   <= CW'(PROD_WIDTH - 1);
         if (bus.modulus == '0) begin
            rem_q <= '0;
            err_q <= 1'b1;
         end
      end else if (state_q == RUN) begin
         r_q     <= r_nxt;
         shift_q <= shift_q << 1;
         cnt_q   <= cnt_q - 1'b1;
         if (cnt_q == '0) begin
            rem_q <= r_nxt;
            err_q <= 1'b0;
         end
      end
   end

   assign bus.remainder = rem_q;
   assign bus.err_mod0  = err_q;
endmodule

// File: tb/tb_modular_remainder_unit.sv
// Directed and randomised checks of the modular remainder unit against a result scoreboard.
module tb_modular_remainder_unit;
   localparam int PW = 96;
   localparam int MW = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   modular_remainder_unit_if #(.PROD_WIDTH(PW), .MOD_WIDTH(MW)) bus();

   modular_remainder_unit #(.PROD_WIDTH(PW), .MOD_WIDTH(MW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct packed {
      logic [MW-1:0] rem;
      logic          err;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int n_acc    = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [PW-1:0] p, input logic [MW-1:0] m,
                       input logic [MW-1:0] exp_rem, input logic exp_err);
      int k;
      exp_t e;
      bus.product  = p;
      bus.modulus  = m;
      bus.in_valid = 1'b1;
      k = 0;
      while (!bus.in_ready && k < 400) begin
         step();
         k++;
      end
      if (k >= 400) chk("accept_timeout", 128'(bus.in_ready), 128'd1);
      e.rem = exp_rem;
      e.err = exp_err;
      sb.push_back(e);
      n_acc++;
      step();
      bus.in_valid = 1'b0;
      bus.product  = {$urandom(), $urandom(), $urandom()};
      bus.modulus  = {$urandom(), $urandom()};
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
         step();
         lat++;
      end
   endtask

   task automatic drain(input bit rand_ready);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 1000) begin
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
         step();
         k++;
      end
      if (k >= 1000) chk("drain_timeout", 128'(sb.size()), 128'd0);
      bus.out_ready = 1'b1;
   endtask

   // Result check happens at negedge, before the handshake edge completes it.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         n_checks++;
         assert (sb.size() > 0) n_pass++;
         else begin
            n_fail++;
            $error("FAIL unexpected_output: observed result with no pending op, required none");
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("remainder", 128'(bus.remainder), 128'(e.rem));
            chk("err_mod0", 128'(bus.err_mod0), 128'(e.err));
            n_out++;
         end
      end
   end

   initial begin
      int lat;
      logic [PW-1:0] p;
      logic [MW-1:0] m;
      logic [PW-1:0] q;

      bus.in_valid  = 1'b0;
      bus.product   = '0;
      bus.modulus   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_remainder", 128'(bus.remainder), 128'd0);
      chk("rst_err_mod0", 128'(bus.err_mod0), 128'd0);
      rst_n = 1'b1;
      step();

      // T1: basic op and latency
      send(96'd100, 64'd7, 64'd2, 1'b0);
      wait_out(lat);
      chk("t1_latency", 128'(lat), 128'd96);
      drain(1'b0);

      // T2: extremes and boundaries
      send({PW{1'b1}}, {MW{1'b1}}, 64'h0000_0000_FFFF_FFFF, 1'b0);
      drain(1'b0);
      send(96'd5, 64'd9, 64'd5, 1'b0);
      drain(1'b0);
      p = 96'd1 << 95;
      send(p, 64'd1, 64'd0, 1'b0);
      drain(1'b0);
      send(96'd0, 64'd12345, 64'd0, 1'b0);
      drain(1'b0);

      // T3: zero modulus, then recovery
      send(96'd123, 64'd0, 64'd0, 1'b1);
      wait_out(lat);
      chk("t3_mod0_latency", 128'(lat), 128'd0);
      drain(1'b0);
      send(96'd10, 64'd3, 64'd1, 1'b0);
      drain(1'b0);

      // T4: backpressure in DONE with ignored in_valid pulses
      bus.out_ready = 1'b0;
      send(96'd1000003, 64'd1000, 64'd3, 1'b0);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0];
         bus.product  = 96'd7;
         bus.modulus  = 64'd5;
         step();
         chk("t4_out_valid", 128'(bus.out_valid), 128'd1);
         chk("t4_remainder", 128'(bus.remainder), 128'd3);
         chk("t4_in_ready", 128'(bus.in_ready), 128'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("t4_in_ready_after", 128'(bus.in_ready), 128'd1);
      chk("t4_out_valid_after", 128'(bus.out_valid), 128'd0);
      chk("t4_sb_empty", 128'(sb.size()), 128'd0);

      // T5: reset in the middle of an operation
      send({32'hDEAD_BEEF, 32'h1234_5678, 32'h9ABC_DEF0}, 64'h0123_4567, 64'd0, 1'b0);
      repeat (40) step();
      rst_n = 1'b0;
      sb.delete();
      n_acc--;
      #1;
      chk("t5_out_valid", 128'(bus.out_valid), 128'd0);
      chk("t5_remainder", 128'(bus.remainder), 128'd0);
      chk("t5_in_ready", 128'(bus.in_ready), 128'd1);
      chk("t5_err_mod0", 128'(bus.err_mod0), 128'd0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("t5_no_output", 128'(bus.out_valid), 128'd0);
      send(96'd1000, 64'd999, 64'd1, 1'b0);
      drain(1'b0);

      // T6: random operands, random gaps and backpressure
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 3)) step();
         case ($urandom_range(0, 2))
            0: p = {$urandom(), $urandom(), $urandom()};
            1: p = 96'($urandom());
            default: p = {32'd0, $urandom(), $urandom()};
         endcase
         case ($urandom_range(0, 2))
            0: m = {$urandom(), $urandom()};
            1: m = 64'($urandom_range(1, 20));
            default: m = 64'($urandom());
         endcase
         if (m == '0) m = 64'd1;
         q = p % {32'd0, m};
         send(p, m, q[MW-1:0], 1'b0);
         drain(1'b1);
      end

      step();
      chk("results_count", 128'(n_out), 128'(n_acc));
      chk("sb_final_empty", 128'(sb.size()), 128'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
